// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
package dmem_pkg;

    // func3 size codes of RV32 loads and stores
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Size codes with no meaning for the access kind (an unsigned-byte store included)
    function automatic logic size_illegal(input logic [2:0] sz, input logic is_store);
        return (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111) ||
               (is_store && (sz == SZ_BU));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and lane replication, load
// shift/extend, and natural-alignment check for halfword/word accesses.
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_raw,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_shifted;

    assign w_shifted = i_raw >> {i_lane, 3'b000};

    // Decode enables, replicated store data and formatted load data from the size code
    always_comb begin
        o_be        = 4'b0000;
        o_wdata_rep = i_wdata;
        o_rdata     = '0;
        o_misalign  = 1'b0;
        case (i_size)
            SZ_B, SZ_BU: begin
                o_be        = 4'b0001 << i_lane;
                o_wdata_rep = {4{i_wdata[7:0]}};
                o_rdata     = (i_size == SZ_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                               : {24'h0, w_shifted[7:0]};
            end
            SZ_H, SZ_HU: begin
                o_be        = 4'b0011 << i_lane;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_rdata     = (i_size == SZ_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                               : {16'h0, w_shifted[15:0]};
                o_misalign  = i_lane[0];
            end
            SZ_W: begin
                o_be        = 4'b1111;
                o_wdata_rep = i_wdata;
                o_rdata     = w_shifted;
                o_misalign  = (i_lane != 2'b00);
            end
            default: begin
                o_be        = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage: one request at a time,
// optional wait states, byte-lane array, one-cycle response strobe.
// Handshake: a request is taken on any clock where req_valid=1 and busy=0;
// exactly one resp_valid pulse follows, with fault qualifying it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              MemRW,
    input  logic [2:0]        Size,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              resp_valid,
    output logic              fault,
    output logic              busy,
    output state_t            o_dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    state_t              r_state;
    state_t              w_next_state;
    logic [WCNT_W-1:0]   r_cnt;
    logic                r_rw;
    logic [2:0]          r_size;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_wdata;
    logic [DWIDTH-1:0]   r_word;
    logic [DWIDTH-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic [IDX_W-1:0]    w_idx;
    logic                w_range_err;
    logic                w_misalign;
    logic                w_fault;
    logic [3:0]          w_be;
    logic [DWIDTH-1:0]   w_wdata_rep;
    logic [DWIDTH-1:0]   w_load_data;

    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_idx       = r_addr[IDX_W+1:2];
    assign w_range_err = |(r_addr >> (IDX_W + 2));
    assign w_fault     = size_illegal(r_size, r_rw) | w_misalign | w_range_err;

    mem_lane_align u_align (
        .i_size      (r_size),
        .i_lane      (r_addr[1:0]),
        .i_wdata     (r_wdata),
        .i_raw       (r_word),
        .o_be        (w_be),
        .o_wdata_rep (w_wdata_rep),
        .o_rdata     (w_load_data),
        .o_misalign  (w_misalign)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (r_cnt == '0) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state; data and fault only during RESP
    always_comb begin
        busy        = (r_state != ST_IDLE);
        resp_valid  = (r_state == ST_RESP);
        fault       = resp_valid && w_fault;
        rdata       = (resp_valid && !w_fault && !r_rw) ? w_load_data : '0;
        o_dbg_state = r_state;
    end

    // Wait-state counter: loaded on accept, counts down while waiting
    always_ff @(posedge clk) begin
        if (rst)                                r_cnt <= '0;
        else if (w_accept)                      r_cnt <= WAIT_LOAD;
        else if (r_state == ST_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end

    // Capture all request fields on accept so later input changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw    <= 1'b0;
            r_size  <= SZ_W;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_rw    <= MemRW;
            r_size  <= Size;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // Byte-enabled store during ACCESS; reset in the same cycle cancels it
    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_ACCESS && r_rw && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
        end
    end

    // Synchronous array read during ACCESS, formatted in RESP
    always_ff @(posedge clk) begin
        if (rst)                         r_word <= '0;
        else if (r_state == ST_ACCESS)   r_word <= r_mem[w_idx];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (no wait states, three wait
// states), byte-addressed reference memory, queued expected responses.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        rst_s   [2];
    logic        req_s   [2];
    logic        rw_s    [2];
    logic [2:0]  size_s  [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        rv_s    [2];
    logic        fault_s [2];
    logic        busy_s  [2];
    state_t      dbg_s   [2];

    int          lat [2] = '{2, 5};

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          cyc_q0[$];
    int          cyc_q1[$];
    logic [7:0]  ref_mem [2][4*DEPTH];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst_s[0]), .req_valid(req_s[0]), .MemRW(rw_s[0]), .Size(size_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .resp_valid(rv_s[0]),
        .fault(fault_s[0]), .busy(busy_s[0]), .o_dbg_state(dbg_s[0])
    );

    dmem_responder #(.AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst_s[1]), .req_valid(req_s[1]), .MemRW(rw_s[1]), .Size(size_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .resp_valid(rv_s[1]),
        .fault(fault_s[1]), .busy(busy_s[1]), .o_dbg_state(dbg_s[1])
    );

    // ---------------- reference model ----------------
    // Returns {fault, rdata}; stores update the byte array.
    function automatic logic [32:0] model(input int u, input bit rw, input logic [2:0] sz,
                                          input logic [31:0] a, input logic [31:0] wd);
        bit          f;
        int          n;
        logic [31:0] v;
        f = (sz == 3'd3) || (sz == 3'd6) || (sz == 3'd7) || (rw && sz == 3'd4) ||
            ((sz == 3'd1 || sz == 3'd5) && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
            (a >= 32'(4*DEPTH));
        if (f) return {1'b1, 32'h0};
        n = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        if (rw) begin
            for (int i = 0; i < n; i++) ref_mem[u][int'(a) + i] = wd[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[u][int'(a) + i];
        if (!sz[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!sz[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return {1'b0, v};
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_exp(input int u, input logic [32:0] e, input int at);
        if (u == 0) begin exp_q0.push_back(e); cyc_q0.push_back(at); end
        else        begin exp_q1.push_back(e); cyc_q1.push_back(at); end
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic wait_idle(input int u);
        int n = 0;
        while (busy_s[u] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (busy_s[u] !== 1'b0) begin
            total++; bad++;
            $display("FAIL idle_wait u%0d: busy=%b want=0 after 50 cycles", u, busy_s[u]);
        end
    endtask

    task automatic issue(input int u, input bit rw, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        wait_idle(u);
        push_exp(u, model(u, rw, sz, a, wd), cyc + lat[u]);
        req_s[u] = 1'b1; rw_s[u] = rw; size_s[u] = sz; addr_s[u] = a; wdata_s[u] = wd;
        @(negedge clk);
        req_s[u] = 1'b0;
        rw_s[u] = 1'($urandom); size_s[u] = 3'($urandom);
        addr_s[u] = $urandom; wdata_s[u] = $urandom;
    endtask

    task automatic drain(input int u);
        int n = 0;
        while (((u == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        total++;
        if (((u == 0) ? exp_q0.size() : exp_q1.size()) != 0) begin
            bad++;
            $display("FAIL drain u%0d: %0d responses missing, want 0", u,
                     (u == 0) ? exp_q0.size() : exp_q1.size());
        end
        wait_idle(u);
    endtask

    // ---------------- monitor ----------------
    task automatic monitor();
        logic [32:0] e;
        int          at;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rv_s[u] === 1'b1) begin
                    total++;
                    if (((u == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                        bad++;
                        $display("FAIL resp_u%0d: unexpected response fault=%b rdata=%h at cycle %0d",
                                 u, fault_s[u], rdata_s[u], cyc);
                    end else begin
                        if (u == 0) begin e = exp_q0.pop_front(); at = cyc_q0.pop_front(); end
                        else        begin e = exp_q1.pop_front(); at = cyc_q1.pop_front(); end
                        if ({fault_s[u], rdata_s[u]} !== e || cyc != at) begin
                            bad++;
                            $display("FAIL resp_u%0d: got fault=%b rdata=%h cycle=%0d, want fault=%b rdata=%h cycle=%0d",
                                     u, fault_s[u], rdata_s[u], cyc, e[32], e[31:0], at);
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [32:0] e;
        int          t0;
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; req_s[u] = 1'b0; rw_s[u] = 1'b0; size_s[u] = 3'd0;
            addr_s[u] = '0; wdata_s[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset_busy_u%0d", u),  32'(busy_s[u]),  32'h0);
            chk($sformatf("reset_rv_u%0d", u),    32'(rv_s[u]),    32'h0);
            chk($sformatf("reset_fault_u%0d", u), 32'(fault_s[u]), 32'h0);
            chk($sformatf("reset_rdata_u%0d", u), rdata_s[u],      32'h0);
        end
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        fork monitor(); join_none

        // fill a 64-byte window so every later load reads defined data
        for (int w = 0; w < 16; w++) begin
            issue(0, 1'b1, SZ_W, 32'(4*w), $urandom);
            issue(1, 1'b1, SZ_W, 32'(4*w), $urandom);
        end
        drain(0); drain(1);

        // directed formatting, partial stores and faults (no wait states)
        issue(0, 1'b1, SZ_W,  32'h10, 32'hDEADBEEF);
        issue(0, 1'b0, SZ_W,  32'h10, 32'h0);
        issue(0, 1'b0, SZ_B,  32'h13, 32'h0);
        issue(0, 1'b0, SZ_BU, 32'h13, 32'h0);
        issue(0, 1'b0, SZ_H,  32'h12, 32'h0);
        issue(0, 1'b0, SZ_HU, 32'h10, 32'h0);
        issue(0, 1'b1, SZ_B,  32'h11, 32'h00000055);
        issue(0, 1'b0, SZ_W,  32'h10, 32'h0);
        issue(0, 1'b1, SZ_H,  32'h12, 32'h00001234);
        issue(0, 1'b0, SZ_W,  32'h10, 32'h0);
        issue(0, 1'b0, SZ_W,  32'h12, 32'h0);
        issue(0, 1'b1, SZ_H,  32'h11, 32'hFFFF9999);
        issue(0, 1'b0, SZ_W,  32'h10, 32'h0);
        issue(0, 1'b0, 3'b011, 32'h10, 32'h0);
        issue(0, 1'b0, SZ_W,  32'(4*DEPTH), 32'h0);
        issue(0, 1'b1, SZ_BU, 32'h14, 32'h000000AB);
        issue(0, 1'b0, SZ_W,  32'h14, 32'h0);
        drain(0);

        // reset coincident with ACCESS: the store must not land
        issue(0, 1'b1, SZ_W, 32'h24, 32'h01020304);
        drain(0);
        req_s[0] = 1'b1; rw_s[0] = 1'b1; size_s[0] = SZ_W; addr_s[0] = 32'h24; wdata_s[0] = 32'hAAAAAAAA;
        @(negedge clk);
        req_s[0] = 1'b0; rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        chk("rst_access_busy", 32'(busy_s[0]), 32'h0);
        issue(0, 1'b0, SZ_W, 32'h24, 32'h0);
        drain(0);

        // three wait states, req_valid held high: accepts at T and T+6
        wait_idle(1);
        t0 = cyc;
        e = model(1, 1'b0, SZ_W, 32'h10, 32'h0);
        push_exp(1, e, t0 + 5);
        push_exp(1, e, t0 + 11);
        req_s[1] = 1'b1; rw_s[1] = 1'b0; size_s[1] = SZ_W; addr_s[1] = 32'h10;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k <= 11)
                chk($sformatf("hold_busy_k%0d", k), 32'(busy_s[1]),
                    ((k >= 1 && k <= 5) || (k >= 7 && k <= 11)) ? 32'h1 : 32'h0);
        end
        req_s[1] = 1'b0;
        drain(1);

        // reset during WAIT discards the pending store
        issue(1, 1'b1, SZ_W, 32'h20, 32'h11223344);
        drain(1);
        req_s[1] = 1'b1; rw_s[1] = 1'b1; size_s[1] = SZ_W; addr_s[1] = 32'h20; wdata_s[1] = 32'hAAAAAAAA;
        @(negedge clk);
        req_s[1] = 1'b0;
        @(negedge clk);
        rst_s[1] = 1'b1;
        @(negedge clk);
        rst_s[1] = 1'b0;
        chk("rst_wait_busy", 32'(busy_s[1]), 32'h0);
        chk("rst_wait_rv",   32'(rv_s[1]),   32'h0);
        repeat (6) @(negedge clk);
        issue(1, 1'b0, SZ_W, 32'h20, 32'h0);
        drain(1);

        // randomized traffic on both instances
        for (int n = 0; n < 300; n++) begin
            for (int u = 0; u < 2; u++) begin
                bit          rw;
                logic [2:0]  sz;
                logic [31:0] a;
                logic [2:0]  st_sz [4];
                st_sz = '{SZ_B, SZ_H, SZ_W, SZ_BU};
                rw = 1'($urandom_range(0, 1));
                sz = rw ? st_sz[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
                a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
                issue(u, rw, sz, a, $urandom);
            end
        end
        drain(0); drain(1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard bound on the whole run
    initial begin
        #2000000;
        $display("FAIL timeout: run did not finish, cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
